if_prefetch_unit: RTL and testbench

- Parametrised successor to the single-cycle fetch stage.
- Decouples PC generation from a variable-latency instruction memory using a request/response handshake.
- Buffers fetched {pc, inst} pairs in a prefetch FIFO and presents them to decode under valid/ready.
- Supports branch/jump redirect with flush; stale in-flight responses are discarded.

---
 rtl/if_prefetch_unit.sv | 161 ++++++++++++++++
 tb/tb_if_prefetch_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch prefetch unit.
// Generates sequential word-aligned fetch addresses and issues them to a
// variable-latency instruction memory. It keeps the PC of every in-flight
// request in a pending queue and buffers returned {pc, inst} pairs in a
// prefetch FIFO that feeds decode.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// Valid does not wait for ready. Once valid is raised it stays stable until
// the transfer, except on a redirect or reset. Responses need no ready: each
// one always matches the oldest pending request.
//
// Redirect flushes the FIFO. Requests already in flight are not cancelled at
// the memory. They are counted in drop_cnt, and their responses are discarded
// when they return.
module if_prefetch_unit #(
  parameter int            N         = 32,
  parameter logic [N-1:0]  RESET_PC  = '0,
  parameter int            DEPTH     = 4,
  parameter int            MAX_OUTST = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [N-1:0] imem_req_addr,
  input  logic         imem_resp_valid,
  input  logic [N-1:0] imem_resp_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_pc,
  output logic [N-1:0] out_inst
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int OW  = $clog2(MAX_OUTST + 1);
  localparam int OCW = OW + 1;
  localparam int PW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int SW  = CW + OW;

  localparam logic [OCW-1:0] MAX_OUTST_W = OCW'(MAX_OUTST);
  localparam logic [SW-1:0]  DEPTH_W     = SW'(DEPTH);

  // Architectural state
  logic [N-1:0]  fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] pend_rd_q, pend_rd_d;
  logic [PW-1:0] pend_wr_q, pend_wr_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] drop_q, drop_d;

  // Storage arrays. These need no reset because the pointers and counts
  // decide which entries are valid.
  logic [N-1:0]  fifo_pc_q   [DEPTH];
  logic [N-1:0]  fifo_inst_q [DEPTH];
  logic [N-1:0]  pend_pc_q   [MAX_OUTST];

  logic [OCW-1:0] occ;
  logic [SW-1:0]  credit_sum;
  logic           resp_ok, resp_keep, resp_drop;
  logic           accept, pop;
  logic           unused_bits;

  // The low two bits of redirect_pc are replaced by zero, so they are not read.
  assign unused_bits = ^redirect_pc[1:0];

  function automatic logic [PW-1:0] pend_inc(input logic [PW-1:0] p);
    if (p == PW'(MAX_OUTST - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Occupancy of the pending queue: live requests plus ones waiting to be dropped
  assign occ        = OCW'(outst_q) + OCW'(drop_q);
  // Credit for the FIFO counts only live requests, because dropped ones never land in it
  assign credit_sum = SW'(count_q) + SW'(outst_q);

  // A response when nothing is pending is ignored completely
  assign resp_ok   = imem_resp_valid && (occ != '0);
  assign resp_drop = resp_ok && (drop_q != '0);
  assign resp_keep = resp_ok && (drop_q == '0);

  // Request issue is gated by reset so that outputs go low as soon as reset asserts
  assign imem_req_valid = reset && !redirect && (occ < MAX_OUTST_W) && (credit_sum < DEPTH_W);
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign out_valid = (count_q != '0);
  assign out_pc    = out_valid ? fifo_pc_q[rd_ptr_q]   : '0;
  assign out_inst  = out_valid ? fifo_inst_q[rd_ptr_q] : '0;
  assign pop       = out_valid && out_ready;

  // Next-state logic for fetch PC, FIFO and pending-queue bookkeeping
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    pend_rd_d  = pend_rd_q;
    pend_wr_d  = pend_wr_q;
    outst_d    = outst_q;
    drop_d     = drop_q;

    // Every accepted response retires the oldest pending entry, including when a redirect happens
    if (resp_ok) pend_rd_d = pend_inc(pend_rd_q);
    if (accept)  pend_wr_d = pend_inc(pend_wr_q);

    if (redirect) begin
      fetch_pc_d = {redirect_pc[N-1:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      outst_d    = '0;
      // Live requests become drops. A response arriving in this same cycle is already retired.
      drop_d     = drop_q + outst_q - (resp_ok ? OW'(1) : OW'(0));
    end else begin
      if (accept)    fetch_pc_d = fetch_pc_q + N'(4);
      if (resp_keep) wr_ptr_d   = wr_ptr_q + 1'b1;
      if (pop)       rd_ptr_d   = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(resp_keep) - CW'(pop);
      outst_d = outst_q + OW'(accept) - OW'(resp_keep);
      drop_d  = drop_q - OW'(resp_drop);
    end
  end

  // Control state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      pend_rd_q  <= '0;
      pend_wr_q  <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pend_rd_q  <= pend_rd_d;
      pend_wr_q  <= pend_wr_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // Data storage: record the PC of each issued request and store the {pc, inst} pairs that are kept
  always_ff @(posedge clk) begin
    if (accept) pend_pc_q[pend_wr_q] <= fetch_pc_q;
    if (resp_keep && !redirect) begin
      fifo_pc_q[wr_ptr_q]   <= pend_pc_q[pend_rd_q];
      fifo_inst_q[wr_ptr_q] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Testbench for if_prefetch_unit. It includes a fixed-latency in-order
// memory model, a cycle table for streaming and backpressure, and directed
// sequences for redirect, address wrap and mid-stream reset.
module tb_if_prefetch_unit;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         redirect = 1'b0;
  logic [N-1:0] redirect_pc = '0;
  logic         imem_req_valid;
  logic         imem_req_ready = 1'b1;
  logic [N-1:0] imem_req_addr;
  logic         imem_resp_valid;
  logic [N-1:0] imem_resp_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_pc;
  logic [N-1:0] out_inst;

  // Clock / reset block
  always #5 clk = ~clk;

  if_prefetch_unit #(
    .N(N), .RESET_PC(32'h0000_0000), .DEPTH(4), .MAX_OUTST(2)
  ) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst)
  );

  function automatic logic [N-1:0] mem_f(input logic [N-1:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // Memory model: an in-order response mem_lat cycles after each accept
  int           cyc = 0;
  int           mem_lat = 1;
  int           stray_at = -1;
  logic [N-1:0] mq_addr[$];
  int           mq_due[$];
  logic         mdl_valid = 1'b0;
  logic [N-1:0] mdl_data = '0;
  logic         stray;

  // A single stray response during the first cycle after reset release
  assign stray           = reset && (cyc == stray_at);
  assign imem_resp_valid = mdl_valid | stray;
  assign imem_resp_data  = stray ? 32'hBAD0_BAD0 : mdl_data;

  always @(posedge clk) begin
    if (!reset) begin
      mq_addr.delete();
      mq_due.delete();
    end else begin
      if (mdl_valid && mq_addr.size() > 0) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + mem_lat);
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (reset && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      mdl_valid = 1'b1;
      mdl_data  = mem_f(mq_addr[0]);
    end else begin
      mdl_valid = 1'b0;
      mdl_data  = '0;
    end
  end

  // Scoreboard
  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Driver: hold reset, check reset outputs, release on a negedge
  task automatic reset_and_release(input int lat);
    reset    = 1'b0;
    redirect = 1'b0;
    repeat (2) @(negedge clk);
    mem_lat = lat;
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    @(negedge clk);
    reset    = 1'b1;
    stray_at = cyc;
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic chk_req(input string name, input logic v, input logic [N-1:0] a);
    check({name, "_req_valid"}, {31'b0, imem_req_valid}, {31'b0, v});
    check({name, "_req_addr"}, imem_req_addr, a);
  endtask

  typedef struct {
    logic         rdy;
    logic         exp_rv;
    logic [N-1:0] exp_addr;
    logic         exp_ov;
    logic [N-1:0] exp_pc;
  } vec_t;

  vec_t vecs[21];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit found;

    // Streaming, then 10 cycles of backpressure, then release (zero-wait memory)
    vecs[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    vecs[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    vecs[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
    vecs[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h08};
    vecs[6]  = '{1'b0, 1'b0, 32'h18, 1'b1, 32'h08};
    for (int i = 7; i <= 13; i++) vecs[i] = '{1'b0, 1'b0, 32'h18, 1'b1, 32'h08};
    vecs[14] = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h08};
    vecs[15] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
    vecs[16] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
    vecs[17] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
    vecs[18] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
    vecs[19] = '{1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};
    vecs[20] = '{1'b1, 1'b1, 32'h2C, 1'b1, 32'h20};

    reset_and_release(1);
    for (int i = 0; i < 21; i++) begin
      out_ready = vecs[i].rdy;
      #1;
      chk_req($sformatf("vec%0d", i), vecs[i].exp_rv, vecs[i].exp_addr);
      check($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_ov});
      if (vecs[i].exp_ov) begin
        check($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].exp_pc);
        check($sformatf("vec%0d_out_inst", i), out_inst, mem_f(vecs[i].exp_pc));
      end
      @(negedge clk);
    end

    // Latency 3: redirect while two requests are outstanding
    out_ready = 1'b0;
    reset_and_release(3);
    out_ready = 1'b1;
    #1; chk_req("lat3_c0", 1'b1, 32'h0);
    step; chk_req("lat3_c1", 1'b1, 32'h4);
    step; chk_req("lat3_c2", 1'b0, 32'h8);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk); redirect = 1'b0; #1;
    chk_req("lat3_c3", 1'b0, 32'h100);
    check("lat3_c3_out_valid", {31'b0, out_valid}, 32'd0);
    step; chk_req("lat3_c4", 1'b1, 32'h100);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      step;
      if (out_valid) begin
        found = 1'b1;
        check("lat3_first_pc", out_pc, 32'h100);
        check("lat3_first_inst", out_inst, mem_f(32'h100));
      end
    end
    if (!found) check("lat3_timeout_out_valid", 32'd0, 32'd1);

    // Redirect in the same cycle as a response arrives (zero-wait memory)
    out_ready = 1'b0;
    reset_and_release(1);
    out_ready = 1'b1;
    step; step; step;
    redirect = 1'b1; redirect_pc = 32'h0000_0200; #1;
    chk_req("rsame_c3", 1'b0, 32'h0C);
    check("rsame_c3_out_pc", out_pc, 32'h4);
    @(negedge clk); redirect = 1'b0; #1;
    check("rsame_c4_out_valid", {31'b0, out_valid}, 32'd0);
    chk_req("rsame_c4", 1'b1, 32'h200);
    step; check("rsame_c5_out_valid", {31'b0, out_valid}, 32'd0);
    step;
    check("rsame_c6_out_valid", {31'b0, out_valid}, 32'd1);
    check("rsame_c6_out_pc", out_pc, 32'h200);
    check("rsame_c6_out_inst", out_inst, mem_f(32'h200));

    // Address wrap at the top of the address space
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    @(negedge clk); redirect = 1'b0; #1;
    chk_req("wrap_c0", 1'b1, 32'hFFFF_FFFC);
    step; chk_req("wrap_c1", 1'b1, 32'h0000_0000);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      if (out_valid) begin
        logic [N-1:0] e;
        e = exp_q.pop_front();
        check("wrap_out_pc", out_pc, e);
        check("wrap_out_inst", out_inst, mem_f(e));
      end
      step;
    end
    if (exp_q.size() > 0) check("wrap_timeout_remaining", exp_q.size(), 32'd0);

    // Reset asserted mid-cycle with the FIFO full
    out_ready = 1'b0;
    repeat (8) step;
    check("full_out_valid", {31'b0, out_valid}, 32'd1);
    check("full_req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk); out_ready = 1'b1; #1;
    check("full_popready_req_valid", {31'b0, imem_req_valid}, 32'd0);
    #1; reset = 1'b0; #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("midrst_out_pc", out_pc, 32'd0);
    reset_and_release(1);
    #1; chk_req("post_rst_c0", 1'b1, 32'h0);
    check("post_rst_c0_out_valid", {31'b0, out_valid}, 32'd0);
    step; chk_req("post_rst_c1", 1'b1, 32'h4);
    step;
    check("post_rst_c2_out_pc", out_pc, 32'h0);
    check("post_rst_c2_out_inst", out_inst, mem_f(32'h0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
